layer_reader: RTL

Read-back engine for the layer result memories that the convolution datapath writes through cwr/caddr_wr/cdata_wr/csel. It issues sequential reads on the crd/caddr_rd/cdata_rd port for a selected memory (csel) and streams the words out over a valid/ready interface, in address order. It sits beside the CONV top and gives post-processing stages (pooling, dump/check logic) a back-pressurable stream. A small credit-controlled prefetch FIFO hides the 1-cycle memory read latency.

---
 rtl/layer_reader_pkg.sv | 23 ++
 rtl/layer_reader_fifo.sv | 48 ++++
 rtl/layer_reader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/layer_reader_pkg.sv
// Shared widths, memory-select encodings and FSM states for the layer result
// memory read-back path.
package layer_reader_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;
    localparam int SEL_W  = 3;

    // Same select codes the convolution write side drives on csel
    localparam logic [SEL_W-1:0] L0_MEM0 = 3'd0;
    localparam logic [SEL_W-1:0] L0_MEM1 = 3'd1;
    localparam logic [SEL_W-1:0] L1_MEM0 = 3'd2;
    localparam logic [SEL_W-1:0] L1_MEM1 = 3'd3;
    localparam logic [SEL_W-1:0] L2_MEM0 = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/layer_reader_fifo.sv
// Small synchronous FIFO; the head entry is presented combinationally from the
// storage registers so a pushed word is visible the cycle after the push.
module sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/layer_reader.sv
// Streams a contiguous address range of one layer result memory out over a
// valid/ready port, prefetching into a credit-limited FIFO.
module layer_reader #(
    parameter int ADDR_W     = layer_reader_pkg::ADDR_W,
    parameter int DATA_W     = layer_reader_pkg::DATA_W,
    parameter int SEL_W      = layer_reader_pkg::SEL_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_busy,
    output logic              o_crd,
    output logic [ADDR_W-1:0] o_caddr_rd,
    output logic [SEL_W-1:0]  o_csel,
    input  logic [DATA_W-1:0] i_cdata_rd,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_done
);

    import layer_reader_pkg::*;

    localparam int CNT_W  = ADDR_W + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W  = FCNT_W + 1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  delivered_q;
    logic              rd_last_p0;
    logic              rd_vld_p1;
    logic              rd_last_p1;

    logic              issue;
    logic              room;
    logic [OCC_W-1:0]  occ_ahead;
    logic [CNT_W-1:0]  cnt_base;
    logic [ADDR_W-1:0] addr_base;
    logic [CNT_W-1:0]  len_eff;

    logic              push;
    logic              pop;
    logic [DATA_W:0]   fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;

    // A read decided now lands in the FIFO two cycles later, so count every
    // word already buffered or in flight, crediting a pop happening this cycle.
    always_comb begin
        occ_ahead = OCC_W'(fifo_count) + OCC_W'(rd_vld_p1) + OCC_W'(o_crd) - OCC_W'(pop);
        room      = !fifo_full && (occ_ahead < OCC_W'(FIFO_DEPTH));
        cnt_base  = (state == IDLE) ? '0 : issued_q;
        addr_base = (state == IDLE) ? i_base : base_q;
        len_eff   = (state == IDLE) ? i_len : len_q;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = (i_len == '0) ? DONE : RUN;
                    issue      = (i_len != '0);
                end
            end
            RUN: begin
                if (issued_q == len_q) state_next = DRAIN;
                else                   issue      = room;
            end
            DRAIN: begin
                if ((pop && (delivered_q + CNT_W'(1) == len_q)) ||
                    (fifo_empty && !o_crd && !rd_vld_p1))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: read strobe/address to memory; stage p1: data returns and is pushed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_crd       <= 1'b0;
            o_caddr_rd  <= '0;
            o_csel      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            rd_last_p0  <= 1'b0;
            rd_vld_p1   <= 1'b0;
            rd_last_p1  <= 1'b0;
        end else begin
            state      <= state_next;
            o_busy     <= (state_next != IDLE);
            o_done     <= (state_next == DONE);
            o_crd      <= issue;
            rd_vld_p1  <= o_crd;
            rd_last_p1 <= rd_last_p0;
            if (state == IDLE && i_start) begin
                o_csel      <= i_sel;
                base_q      <= i_base;
                len_q       <= i_len;
                issued_q    <= '0;
                delivered_q <= '0;
            end else if (pop) begin
                delivered_q <= delivered_q + CNT_W'(1);
            end
            if (issue) begin
                o_caddr_rd <= addr_base + cnt_base[ADDR_W-1:0];
                issued_q   <= cnt_base + CNT_W'(1);
                rd_last_p0 <= (cnt_base + CNT_W'(1) == len_eff);
            end
        end
    end

    assign push = rd_vld_p1;
    assign pop  = o_valid && i_ready;

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({rd_last_p1, i_cdata_rd}),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_valid = !fifo_empty;
    assign o_data  = fifo_head[DATA_W-1:0];
    assign o_last  = o_valid && fifo_head[DATA_W];

    assert property (@(posedge clk) disable iff (reset) !(push && fifo_full && !pop));

endmodule
